// File: rtl/instr_sequencer_pkg.sv
// Shared types for the picoMIPS control side: opcodes, sequencer states and ALU functions.
package cpuConfig;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_ADDI = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4,
        OP_MULI = 3'd5,
        OP_IN   = 3'd6,
        OP_J    = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH        = 2'd0,
        EXEC         = 2'd1,
        WAIT_PRESS   = 2'd2,
        WAIT_RELEASE = 2'd3
    } seqState_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_SUB    = 2'd1,
        ALU_MUL    = 2'd2,
        ALU_PASS_B = 2'd3
    } aluFunc_t;

    localparam int GO_BIT = 8;

endpackage

// File: rtl/instr_sequencer_decoder.sv
// Combinational instruction decoder: splits the instruction register into fields
// and derives the ALU control lines.
module instr_decoder
    import cpuConfig::*;
#(
    parameter  int N       = 8,
    parameter  int R_SIZE  = 3,
    localparam int I_WIDTH = 3 + 2 * R_SIZE + N
) (
    input  logic [I_WIDTH-1:0] ir,
    output opcode_t            opcode,
    output aluFunc_t           alu_func,
    output logic               alu_immediate,
    output logic               imm_switches,
    output logic [R_SIZE-1:0]  op_d,
    output logic [R_SIZE-1:0]  op_s,
    output logic [N-1:0]       op_t
);

    assign opcode = opcode_t'(ir[I_WIDTH-1 -: 3]);
    assign op_d   = ir[N+2*R_SIZE-1 -: R_SIZE];
    assign op_s   = ir[N+R_SIZE-1 -: R_SIZE];
    assign op_t   = ir[N-1:0];

    // NOP and J still present ALU_ADD so the data path sees a benign operation.
    always_comb begin
        alu_func      = ALU_ADD;
        alu_immediate = 1'b0;
        imm_switches  = 1'b0;
        case (opcode)
            OP_ADD:  alu_func = ALU_ADD;
            OP_ADDI: begin
                alu_func      = ALU_ADD;
                alu_immediate = 1'b1;
            end
            OP_SUB:  alu_func = ALU_SUB;
            OP_MUL:  alu_func = ALU_MUL;
            OP_MULI: begin
                alu_func      = ALU_MUL;
                alu_immediate = 1'b1;
            end
            OP_IN: begin
                alu_func      = ALU_PASS_B;
                alu_immediate = 1'b1;
                imm_switches  = 1'b1;
            end
            default: alu_func = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// picoMIPS instruction sequencer: pc, IR, fetch/execute FSM and go-button handshake.
// Define SWITCH_SYNC_EN to pass the go button through a 2-flop synchroniser.
module instr_sequencer
    import cpuConfig::*;
#(
    parameter  int N       = 8,
    parameter  int A_SIZE  = 3,
    parameter  int R_SIZE  = 3,
    localparam int I_WIDTH = 3 + 2 * R_SIZE + N
) (
    input  logic               clk,
    input  logic               nReset,
    output logic [A_SIZE-1:0]  pc,
    input  logic [I_WIDTH-1:0] instr,
    input  logic [9:0]         switchesIn,
    output logic               writeReg,
    output aluFunc_t           aluFunc,
    output logic               aluImmediate,
    output logic               immSwitches,
    output logic [R_SIZE-1:0]  opD,
    output logic [R_SIZE-1:0]  opS,
    output logic [N-1:0]       opT,
    output logic               waitingInput
);

    seqState_t           state, state_next;
    logic [A_SIZE-1:0]   pc_next;
    logic [I_WIDTH-1:0]  ir;
    opcode_t             opcode;
    logic                go;

    // Switch data travels through the data path; only the go bit is consumed here.
    logic unused_switches;
    assign unused_switches = ^{switchesIn[9], switchesIn[7:0]};

`ifdef SWITCH_SYNC_EN
    logic go_meta, go_sync;
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            go_meta <= 1'b0;
            go_sync <= 1'b0;
        end else begin
            go_meta <= switchesIn[GO_BIT];
            go_sync <= go_meta;
        end
    end
    assign go = go_sync;
`else
    assign go = switchesIn[GO_BIT];
`endif

    instr_decoder #(.N(N), .R_SIZE(R_SIZE)) u_decoder (
        .ir            (ir),
        .opcode        (opcode),
        .alu_func      (aluFunc),
        .alu_immediate (aluImmediate),
        .imm_switches  (immSwitches),
        .op_d          (opD),
        .op_s          (opS),
        .op_t          (opT)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == FETCH) ir <= instr;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        writeReg     = 1'b0;
        waitingInput = 1'b0;
        case (state)
            FETCH: state_next = EXEC;
            EXEC: begin
                state_next = FETCH;
                case (opcode)
                    OP_NOP: pc_next = pc + 1'b1;
                    OP_J:   pc_next = opT[A_SIZE-1:0];
                    OP_IN:  state_next = WAIT_PRESS;
                    default: begin
                        writeReg = 1'b1;
                        pc_next  = pc + 1'b1;
                    end
                endcase
            end
            WAIT_PRESS: begin
                waitingInput = 1'b1;
                if (go) begin
                    writeReg   = 1'b1;
                    state_next = WAIT_RELEASE;
                end
            end
            // pc only advances once the button is let go, so a held button writes once.
            WAIT_RELEASE: begin
                if (!go) begin
                    pc_next    = pc + 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed ROM programs, register writes checked by a monitor.
module tb_instr_sequencer;
    import cpuConfig::*;

`ifdef SWITCH_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk;
    logic        nReset;
    logic [2:0]  pc;
    logic [16:0] instr;
    logic [9:0]  sw;
    logic        writeReg;
    aluFunc_t    aluFunc;
    logic        aluImmediate;
    logic        immSwitches;
    logic [2:0]  opD;
    logic [2:0]  opS;
    logic [7:0]  opT;
    logic        waitingInput;

    logic [16:0] rom [8];
    assign instr = rom[pc];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] pc;
        logic [2:0] d;
        logic [2:0] s;
        logic [7:0] t;
        aluFunc_t   f;
        logic       ai;
        logic       is;
    } wr_t;

    wr_t exp_q[$];
    wr_t got, want;

    instr_sequencer dut (
        .clk          (clk),
        .nReset       (nReset),
        .pc           (pc),
        .instr        (instr),
        .switchesIn   (sw),
        .writeReg     (writeReg),
        .aluFunc      (aluFunc),
        .aluImmediate (aluImmediate),
        .immSwitches  (immSwitches),
        .opD          (opD),
        .opS          (opS),
        .opT          (opT),
        .waitingInput (waitingInput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] enc(opcode_t op, logic [2:0] rd, logic [2:0] rs, logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic push(logic [2:0] p, logic [2:0] d, logic [2:0] s, logic [7:0] t,
                        aluFunc_t f, logic ai, logic is);
        wr_t e;
        e = '{p, d, s, t, f, ai, is};
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = enc(OP_NOP, 3'd0, 3'd0, 8'd0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        nReset = 1'b1;
    endtask

    // Monitor: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (nReset && writeReg) begin
            got = '{pc, opD, opS, opT, aluFunc, aluImmediate, immSwitches};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h, required no write", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL write_fields: got %h, required %h", got, want);
                end
            end
        end
    end

    initial begin
        nReset = 1'b0;
        sw     = 10'h000;
        clear_rom();
        rom[0] = enc(OP_ADDI, 3'd1, 3'd0, 8'd5);

        // Reset state, then reset in the middle of EXEC of ADDI
        repeat (2) @(posedge clk);
        #1;
        nReset = 1'b1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_write", 32'(writeReg), 0);
        chk("rst_waiting", 32'(waitingInput), 0);
        push(3'd0, 3'd1, 3'd0, 8'd5, ALU_ADD, 1'b1, 1'b0);
        cyc();
        #6;
        nReset = 1'b0;
        #1;
        chk("midrst_pc", 32'(pc), 0);
        chk("midrst_write", 32'(writeReg), 0);
        chk("midrst_opd", 32'(opD), 0);
        chk("midrst_opt", 32'(opT), 0);
        chk("midrst_aluimm", 32'(aluImmediate), 0);
        release_rst();
        chk("refetch_pc", 32'(pc), 0);
        push(3'd0, 3'd1, 3'd0, 8'd5, ALU_ADD, 1'b1, 1'b0);
        cyc();
        cyc();
        chk("addi_pc", 32'(pc), 1);

        // ALU instruction mix, then halt
        nReset = 1'b0;
        clear_rom();
        rom[0] = enc(OP_ADD,  3'd1, 3'd2, 8'd0);
        rom[1] = enc(OP_SUB,  3'd3, 3'd4, 8'd0);
        rom[2] = enc(OP_MUL,  3'd5, 3'd6, 8'd0);
        rom[3] = enc(OP_MULI, 3'd7, 3'd0, 8'h81);
        rom[5] = enc(OP_J,    3'd0, 3'd0, 8'd5);
        push(3'd0, 3'd1, 3'd2, 8'h00, ALU_ADD, 1'b0, 1'b0);
        push(3'd1, 3'd3, 3'd4, 8'h00, ALU_SUB, 1'b0, 1'b0);
        push(3'd2, 3'd5, 3'd6, 8'h00, ALU_MUL, 1'b0, 1'b0);
        push(3'd3, 3'd7, 3'd0, 8'h81, ALU_MUL, 1'b1, 1'b0);
        release_rst();
        repeat (8) cyc();
        chk("mix_pc_after4", 32'(pc), 4);
        repeat (12) cyc();
        chk("mix_pc_halt", 32'(pc), 5);

        // IN with go handshake
        nReset = 1'b0;
        clear_rom();
        rom[0] = enc(OP_IN, 3'd2, 3'd0, 8'h00);
        rom[1] = enc(OP_J,  3'd0, 3'd0, 8'd1);
        sw = 10'h0AA;
        release_rst();
        cyc();
        chk("in_exec_waiting", 32'(waitingInput), 0);
        chk("in_exec_write", 32'(writeReg), 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("in_waiting", 32'(waitingInput), 1);
            chk("in_wait_pc", 32'(pc), 0);
            cyc();
        end
        push(3'd0, 3'd2, 3'd0, 8'h00, ALU_PASS_B, 1'b1, 1'b1);
        sw = 10'h1AA;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("in_hold_pc", 32'(pc), 0);
        end
        chk("in_release_waiting", 32'(waitingInput), 0);
        sw = 10'h0AA;
        repeat (SYNC_LAT) cyc();
        chk("in_pre_release_pc", 32'(pc), 0);
        cyc();
        chk("in_done_pc", 32'(pc), 1);
        repeat (6) cyc();
        chk("in_halt_pc", 32'(pc), 1);

        // pc wraps from 7 to 0
        nReset = 1'b0;
        clear_rom();
        rom[0] = enc(OP_J, 3'd0, 3'd0, 8'd7);
        rom[7] = enc(OP_NOP, 3'd0, 3'd0, 8'd0);
        release_rst();
        repeat (2) cyc();
        chk("wrap_pc7", 32'(pc), 7);
        repeat (2) cyc();
        chk("wrap_pc0", 32'(pc), 0);

        // Jump-to-self halt: pc stays, no writes
        nReset = 1'b0;
        clear_rom();
        rom[0] = enc(OP_J, 3'd0, 3'd0, 8'd3);
        rom[3] = enc(OP_J, 3'd0, 3'd0, 8'd3);
        release_rst();
        repeat (2) cyc();
        for (int i = 0; i < 10; i++) begin
            chk("halt_pc", 32'(pc), 3);
            chk("halt_write", 32'(writeReg), 0);
            cyc();
        end

        chk("pending_writes", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
